// File: rtl/pagerank_gather_accum_if.sv
// Scatter-lane input bus and drained-rank output stream of the PageRank gather accumulator.
// Both directions use valid/ready: a transfer happens on a rising edge where valid && ready.
interface pagerank_gather_accum_if #(
  parameter int LANES  = 2,
  parameter int DATA_W = 64,
  parameter int ID_W   = 5
);
  logic [LANES-1:0]             in_valid;
  logic [LANES-1:0][DATA_W-1:0] in_rank;
  logic [LANES-1:0][ID_W-1:0]   in_dest;
  logic                         in_ready;
  logic                         out_valid;
  logic                         out_ready;
  logic [ID_W-1:0]              out_id;
  logic [DATA_W-1:0]            out_rank;

  modport master (
    output in_valid, in_rank, in_dest, out_ready,
    input  in_ready, out_valid, out_id, out_rank
  );

  modport slave (
    input  in_valid, in_rank, in_dest, out_ready,
    output in_ready, out_valid, out_id, out_rank
  );
endinterface

// File: rtl/pagerank_gather_accum.sv
// Gather-phase accumulator: sums scatter contributions per node, then drains damped ranks in id order.
// Optional damping datapath is compiled in when PR_DAMPING_EN is defined.
module pagerank_gather_accum #(
  parameter int NODES_IN_GRAPH = 32,
  parameter int DATA_W         = 64,
  parameter int LANES          = 2,
  parameter int FRAC_W         = 32,
  parameter int ID_W           = $clog2(NODES_IN_GRAPH)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              scatter_done,
  input  logic [DATA_W-1:0] damp_factor,
  input  logic [DATA_W-1:0] base_term,
  output logic              gather_done,
  output logic              err_range,
  output logic              err_sat,
  output logic [1:0]        dbg_state,
  pagerank_gather_accum_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;
  state_t state, state_nxt;

`ifdef PR_DAMPING_EN
  localparam int S1_W = 2 * DATA_W;
`else
  localparam int S1_W = DATA_W;
`endif

  logic [DATA_W-1:0] acc     [NODES_IN_GRAPH];
  logic [DATA_W-1:0] acc_nxt [NODES_IN_GRAPH];
  logic [DATA_W:0]   lane_sum;
  logic              sat_hit, range_hit, start_take, hs_last;
  logic [ID_W-1:0]   issue_idx, s1_id;
  logic              issue_active, s1_valid, s1_adv, load_s1;
  logic [DATA_W-1:0] acc_sel, out_nxt;
  logic [S1_W-1:0]   s1_in, s1_val;
  logic              out_sat;

  assign start_take = start && (state == IDLE || state == DONE);
  assign hs_last    = bus.out_valid && bus.out_ready && (bus.out_id == ID_W'(NODES_IN_GRAPH - 1));

  // Lanes are folded in lane order with saturating adds; equals saturating the collided total.
  always_comb begin
    acc_nxt   = acc;
    lane_sum  = '0;
    sat_hit   = 1'b0;
    range_hit = 1'b0;
    for (int n = 0; n < NODES_IN_GRAPH; n++) begin
      for (int l = 0; l < LANES; l++) begin
        if (bus.in_valid[l] && bus.in_dest[l] == ID_W'(n)) begin
          lane_sum = {1'b0, acc_nxt[n]} + {1'b0, bus.in_rank[l]};
          if (lane_sum[DATA_W]) begin
            acc_nxt[n] = '1;
            sat_hit    = 1'b1;
          end else begin
            acc_nxt[n] = lane_sum[DATA_W-1:0];
          end
        end
      end
    end
    for (int l = 0; l < LANES; l++)
      if (bus.in_valid[l] && int'(bus.in_dest[l]) >= NODES_IN_GRAPH) range_hit = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int n = 0; n < NODES_IN_GRAPH; n++) acc[n] <= '0;
    end else if (start_take) begin
      for (int n = 0; n < NODES_IN_GRAPH; n++) acc[n] <= '0;
    end else if (state == ACCUM) begin
      acc <= acc_nxt;
    end
  end

  always_comb begin
    acc_sel = '0;
    for (int n = 0; n < NODES_IN_GRAPH; n++)
      if (issue_idx == ID_W'(n)) acc_sel = acc[n];
  end

`ifdef PR_DAMPING_EN
  logic            sh_over;
  logic [DATA_W:0] damp_sum;
  assign s1_in    = ({{DATA_W{1'b0}}, damp_factor} * {{DATA_W{1'b0}}, acc_sel}) >> FRAC_W;
  assign sh_over  = |s1_val[S1_W-1:DATA_W];
  assign damp_sum = {1'b0, base_term} + {1'b0, s1_val[DATA_W-1:0]};
  assign out_sat  = sh_over || damp_sum[DATA_W];
  assign out_nxt  = out_sat ? '1 : damp_sum[DATA_W-1:0];
`else
  logic unused_damp;
  assign unused_damp = ^{damp_factor, base_term};
  assign s1_in       = acc_sel;
  assign out_sat     = 1'b0;
  assign out_nxt     = s1_val;
`endif

  // Two-stage drain pipe: stage 1 reads/multiplies, the output register adds base and saturates.
  assign s1_adv  = !bus.out_valid || bus.out_ready;
  assign load_s1 = issue_active && (!s1_valid || s1_adv);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      issue_idx    <= '0;
      issue_active <= 1'b0;
      s1_valid     <= 1'b0;
      s1_id        <= '0;
      s1_val       <= '0;
      bus.out_valid <= 1'b0;
      bus.out_id    <= '0;
      bus.out_rank  <= '0;
    end else if (state == ACCUM && scatter_done) begin
      issue_idx    <= '0;
      issue_active <= 1'b1;
      s1_valid     <= 1'b0;
    end else begin
      if (load_s1) begin
        s1_valid  <= 1'b1;
        s1_id     <= issue_idx;
        s1_val    <= s1_in;
        issue_idx <= issue_idx + ID_W'(1);
        if (issue_idx == ID_W'(NODES_IN_GRAPH - 1)) issue_active <= 1'b0;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
      if (s1_valid && s1_adv) begin
        bus.out_valid <= 1'b1;
        bus.out_id    <= s1_id;
        bus.out_rank  <= out_nxt;
      end else if (bus.out_valid && bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_range <= 1'b0;
      err_sat   <= 1'b0;
    end else if (start_take) begin
      err_range <= 1'b0;
      err_sat   <= 1'b0;
    end else begin
      if (state == ACCUM && range_hit) err_range <= 1'b1;
      if ((state == ACCUM && sat_hit) || (s1_valid && s1_adv && out_sat)) err_sat <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ACCUM;
      ACCUM:   if (scatter_done) state_nxt = DRAIN;
      DRAIN:   if (hs_last) state_nxt = DONE;
      DONE:    if (start) state_nxt = ACCUM;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready = (state == ACCUM);
    gather_done  = (state == DONE);
    dbg_state    = state;
  end
endmodule

// File: tb/tb_pagerank_gather_accum.sv
// Directed bench for pagerank_gather_accum: a reference accumulator model feeds an expected-rank queue
// that is checked against every drained node, including backpressure and mid-drain reset.
module tb_pagerank_gather_accum;
  localparam int NODES  = 32;
  localparam int DATA_W = 64;
  localparam int LANES  = 2;
  localparam int FRAC_W = 32;
  localparam int ID_W   = 6;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              scatter_done = 1'b0;
  logic [DATA_W-1:0] damp_factor = 64'h0000_0000_D999_999A;
  logic [DATA_W-1:0] base_term   = 64'h0000_0000_0133_3333;
  logic              gather_done, err_range, err_sat;
  logic [1:0]        dbg_state;

  pagerank_gather_accum_if #(.LANES(LANES), .DATA_W(DATA_W), .ID_W(ID_W)) bus ();

  pagerank_gather_accum #(
    .NODES_IN_GRAPH(NODES), .DATA_W(DATA_W), .LANES(LANES), .FRAC_W(FRAC_W), .ID_W(ID_W)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .scatter_done(scatter_done),
    .damp_factor(damp_factor), .base_term(base_term), .gather_done(gather_done),
    .err_range(err_range), .err_sat(err_sat), .dbg_state(dbg_state), .bus(bus)
  );

  always #5 clock = ~clock;

  logic [DATA_W-1:0] exp_acc [NODES];
  logic [DATA_W-1:0] exp_q[$];
  bit                exp_err_sat, exp_err_range;
  int                n_cmp = 0;
  int                n_bad = 0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int n = 0; n < NODES; n++) exp_acc[n] = '0;
    exp_err_sat   = 1'b0;
    exp_err_range = 1'b0;
  endtask

  task automatic model_add(input int d, input logic [63:0] r);
    logic [64:0] s;
    if (d >= NODES) begin
      exp_err_range = 1'b1;
    end else begin
      s = {1'b0, exp_acc[d]} + {1'b0, r};
      if (s[64]) begin
        exp_acc[d]  = '1;
        exp_err_sat = 1'b1;
      end else begin
        exp_acc[d] = s[63:0];
      end
    end
  endtask

  // Returns {saturated, rank} for one node as the drain should present it.
  function automatic logic [64:0] model_rank(input logic [63:0] a);
`ifdef PR_DAMPING_EN
    logic [127:0] prod;
    logic [64:0]  sum;
    prod = ({64'd0, damp_factor} * {64'd0, a}) >> FRAC_W;
    if (prod[127:64] != 0) return {1'b1, 64'hFFFF_FFFF_FFFF_FFFF};
    sum = {1'b0, base_term} + {1'b0, prod[63:0]};
    if (sum[64]) return {1'b1, 64'hFFFF_FFFF_FFFF_FFFF};
    return {1'b0, sum[63:0]};
`else
    return {1'b0, a};
`endif
  endfunction

  task automatic do_start();
    bus.in_valid = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    model_clear();
    check("in_ready_rise", bus.in_ready, 1);
  endtask

  task automatic beat(input bit v0, input logic [63:0] r0, input int d0,
                      input bit v1, input logic [63:0] r1, input int d1);
    bus.in_valid   = {v1, v0};
    bus.in_rank[0] = r0;
    bus.in_dest[0] = ID_W'(d0);
    bus.in_rank[1] = r1;
    bus.in_dest[1] = ID_W'(d1);
    if (v0) model_add(d0, r0);
    if (v1) model_add(d1, r1);
    tick();
    bus.in_valid = '0;
  endtask

  task automatic finish_scatter();
    logic [64:0] mr;
    scatter_done = 1'b1;
    tick();
    scatter_done = 1'b0;
    for (int n = 0; n < NODES; n++) begin
      mr = model_rank(exp_acc[n]);
      if (mr[64]) exp_err_sat = 1'b1;
      exp_q.push_back(mr[63:0]);
    end
  endtask

  // mode 0: out_ready held high; mode 1: out_ready repeats 1,0,0,1. Stops early when stop_id is on the bus.
  task automatic drain(input int mode, input int stop_id);
    logic [3:0] pat = 4'b1001;
    int hs = 0;
    int cyc = 0;
    int exp_id = 0;
    bit stopped = 1'b0;
    while (hs < NODES && cyc < 400 && !stopped) begin
      bus.out_ready = (mode == 0) ? 1'b1 : pat[cyc % 4];
      if (mode == 0 && hs > 0) check("no_bubble", bus.out_valid, 1);
      if (bus.out_valid) begin
        check("drain_id", bus.out_id, exp_id);
        if (exp_q.size() == 0) check("drain_queue_empty", bus.out_rank, 0);
        else                   check("drain_rank", bus.out_rank, exp_q[0]);
        if (stop_id >= 0 && exp_id == stop_id) stopped = 1'b1;
        else if (bus.out_ready) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          exp_id++;
          hs++;
        end
      end
      if (!stopped) begin
        tick();
        cyc++;
      end
    end
    if (!stopped) begin
      check("drain_count", hs, NODES);
      check("gather_done", gather_done, 1);
      check("done_state", dbg_state, 2'd3);
      check("out_valid_after", bus.out_valid, 0);
      check("err_sat", err_sat, exp_err_sat);
      check("err_range", err_range, exp_err_range);
    end
  endtask

  task automatic check_reset_values();
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_id", bus.out_id, 0);
    check("rst_out_rank", bus.out_rank, 0);
    check("rst_gather_done", gather_done, 0);
    check("rst_err_range", err_range, 0);
    check("rst_err_sat", err_sat, 0);
    check("rst_state", dbg_state, 2'd0);
  endtask

  initial begin
    bus.in_valid  = '0;
    bus.in_rank   = '0;
    bus.in_dest   = '0;
    bus.out_ready = 1'b0;
    model_clear();
    repeat (3) @(posedge clock);
    #1;
    check_reset_values();
    @(negedge clock);
    reset_n = 1'b1;
    tick();

    // Same-cycle collision on node 3, plus a single beat to node 1; check drain latency and throughput.
    do_start();
    beat(1'b1, 64'd5, 3, 1'b1, 64'd7, 3);
    beat(1'b1, 64'h1_0000_0000, 1, 1'b0, 64'd0, 0);
    bus.out_ready = 1'b1;
    finish_scatter();
    check("in_ready_fall", bus.in_ready, 0);
    check("lat_cycle1", bus.out_valid, 0);
    tick();
    check("lat_cycle2", bus.out_valid, 0);
    check("gather_done_low", gather_done, 0);
    tick();
    check("lat_first_valid", bus.out_valid, 1);
    drain(0, -1);

    // Back-to-back beats to node 0 saturate; drain with backpressure.
    do_start();
    check("err_sat_cleared", err_sat, 0);
    beat(1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 1'b0, 64'd0, 0);
    beat(1'b1, 64'd5, 0, 1'b0, 64'd0, 0);
    finish_scatter();
    drain(1, -1);

    // start and scatter_done together in DONE: start wins. Then an out-of-range beat is dropped.
    bus.in_valid = '0;
    start = 1'b1;
    scatter_done = 1'b1;
    tick();
    start = 1'b0;
    scatter_done = 1'b0;
    model_clear();
    check("start_wins_ready", bus.in_ready, 1);
    check("start_wins_state", dbg_state, 2'd1);
    beat(1'b1, 64'd9, 40, 1'b0, 64'd0, 0);
    check("err_range_set", err_range, 1);
    finish_scatter();
    drain(0, -1);

    // Random beats with frequent collisions, drained under backpressure.
    do_start();
    for (int i = 0; i < 16; i++)
      beat(1'($urandom_range(0, 1)), 64'($urandom()), $urandom_range(0, 7),
           1'($urandom_range(0, 1)), 64'($urandom()), $urandom_range(0, 7));
    finish_scatter();
    drain(1, -1);

    // Reset while node 10 is on the output, then a fresh iteration drains all zeros.
    do_start();
    beat(1'b1, 64'd3, 10, 1'b1, 64'd4, 20);
    finish_scatter();
    drain(0, 10);
    reset_n = 1'b0;
    #1;
    check_reset_values();
    exp_q.delete();
    model_clear();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    do_start();
    finish_scatter();
    drain(0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
